// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises multi-channel load/store requests onto a
// byte-wide memory port, with flush, stall (rdy_in) and UART back-pressure.
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH-1:0]     req_wr,
    input  logic [2*NUM_CH-1:0]   req_size,
    input  logic [NUM_CH-1:0]     req_signed,
    input  logic [32*NUM_CH-1:0]  req_addr,
    input  logic [32*NUM_CH-1:0]  req_wdata,
    output logic [NUM_CH-1:0]     resp_valid,
    output logic [31:0]           resp_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_n;
    logic              cur_signed;
    logic [2:0]        idx;
    logic              pend;
    logic [31:0]       rbuf;
    logic [NUM_CH-1:0] resp_q;

    logic [NUM_CH-1:0] cand;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   gnt_next_ptr;
    logic              grant;
    logic [31:0]       g_addr;
    logic [31:0]       g_wdata;
    logic              g_wr;
    logic              g_signed;
    logic [1:0]        g_size;
    logic [2:0]        g_n;
    logic [NUM_CH-1:0] ch_onehot;
    logic [1:0]        lane;
    logic [31:0]       ld_raw;
    logic [31:0]       ld_ext;
    logic [7:0]        next_byte;
    logic              io_stall;

    // A channel being answered this cycle must not be re-granted on the same request.
    assign cand = req_valid & ~resp_valid;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        logic [CH_W-1:0] sel;
        sel       = '0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!gnt_found && cand[sel]) begin
                gnt_found = 1'b1;
                gnt_ch    = sel;
            end
        end
    end

    assign gnt_next_ptr = CH_W'((int'(gnt_ch) + 1) % NUM_CH);
    assign grant        = (state == IDLE) && rdy_in && !flush && gnt_found;

    always_comb begin
        g_addr   = '0;
        g_wdata  = '0;
        g_wr     = 1'b0;
        g_signed = 1'b0;
        g_size   = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == gnt_ch) begin
                g_addr   = req_addr[32*k +: 32];
                g_wdata  = req_wdata[32*k +: 32];
                g_wr     = req_wr[k];
                g_signed = req_signed[k];
                g_size   = req_size[2*k +: 2];
            end
        end
        case (g_size)
            2'd0:    g_n = 3'd1;
            2'd1:    g_n = 3'd2;
            default: g_n = 3'd4;
        endcase
    end

    always_comb begin
        ch_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) ch_onehot[k] = (CH_W'(k) == cur_ch);
    end

    // While pend is set, mem_din carries byte idx-1 (addressed in the previous cycle).
    assign lane = idx[1:0] - 2'd1;

    always_comb begin
        ld_raw = rbuf;
        if (pend) ld_raw[{lane, 3'b000} +: 8] = mem_din;
        case (cur_n)
            3'd1:    ld_ext = {{24{cur_signed & ld_raw[7]}},  ld_raw[7:0]};
            3'd2:    ld_ext = {{16{cur_signed & ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    assign next_byte = cur_wdata[{idx[1:0] + 2'd1, 3'b000} +: 8];
    assign io_stall  = (mem_a[17:16] == 2'b11) && io_buffer_full;

    // Stall and UART back-pressure must take effect in the same cycle, so these
    // two strobes are gated combinationally on top of registered state.
    assign mem_wr     = (state == WR) && rdy_in && !io_stall;
    assign resp_valid = resp_q & {NUM_CH{rdy_in}};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            cur_wdata  <= '0;
            cur_n      <= 3'd1;
            cur_signed <= 1'b0;
            idx        <= '0;
            pend       <= 1'b0;
            rbuf       <= '0;
            resp_q     <= '0;
            resp_data  <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
        end else if (!rdy_in) begin
            // The returning byte is only on mem_din for one cycle; keep it across the stall.
            if (state == RD && pend) begin
                rbuf <= ld_raw;
                pend <= 1'b0;
            end
        end else begin
            resp_q <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        rr_ptr     <= gnt_next_ptr;
                        cur_ch     <= gnt_ch;
                        cur_wdata  <= g_wdata;
                        cur_n      <= g_n;
                        cur_signed <= g_signed;
                        idx        <= '0;
                        pend       <= 1'b0;
                        rbuf       <= '0;
                        mem_a      <= g_addr;
                        mem_dout   <= g_wr ? g_wdata[7:0] : 8'h00;
                        state      <= g_wr ? WR : RD;
                    end
                end
                RD: begin
                    if (flush) begin
                        state <= IDLE;
                        mem_a <= '0;
                        pend  <= 1'b0;
                    end else begin
                        rbuf <= ld_raw;
                        if (idx == cur_n) begin
                            state     <= IDLE;
                            mem_a     <= '0;
                            pend      <= 1'b0;
                            resp_q    <= ch_onehot;
                            resp_data <= ld_ext;
                        end else begin
                            idx  <= idx + 3'd1;
                            pend <= 1'b1;
                            if (idx + 3'd1 < cur_n) mem_a <= mem_a + 32'd1;
                        end
                    end
                end
                WR: begin
                    if (!io_stall) begin
                        if (idx + 3'd1 == cur_n) begin
                            state     <= IDLE;
                            mem_a     <= '0;
                            mem_dout  <= '0;
                            resp_q    <= ch_onehot;
                            resp_data <= '0;
                        end else begin
                            idx      <= idx + 3'd1;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: loads, stores, arbitration, IO back-pressure,
// flush, stall and reset, each scenario checking against hand-computed values.
module tb_mem_arbiter;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_wr = '0;
    logic [1:0]  req_signed = '0;
    logic [3:0]  req_size = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  mem [0:255];
    int total = 0;
    int bad = 0;

    mem_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Read byte is returned the cycle after its address.
    always @(posedge clk_in) mem_din <= mem[mem_a[7:0]];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic set_req(input int c, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
        req_valid[c]          = 1'b1;
        req_wr[c]             = wr;
        req_size[2*c +: 2]    = sz;
        req_signed[c]         = sg;
        req_addr[32*c +: 32]  = a;
        req_wdata[32*c +: 32] = wd;
    endtask

    task automatic wait_resp(input int c, input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (resp_valid[c]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        cyc();
        cyc();
        rst_in = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #3;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        cyc();
        cyc();
        rst_in = 1'b1;
        cyc();
    endtask

    task automatic test_word_load();
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        #1;
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL wl_idle_mem_a: got %h want 0", mem_a); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (mem_a !== 32'h100 + 32'(i)) begin bad++; $display("FAIL wl_mem_a[%0d]: got %h want %h", i, mem_a, 32'h100 + 32'(i)); end
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL wl_mem_wr[%0d]: got %b want 0", i, mem_wr); end
        end
        cyc();
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL wl_resp_early: got %b want 00", resp_valid); end
        cyc();
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL wl_resp_valid: got %b want 01", resp_valid); end
        total++; if (resp_data !== 32'h84332211) begin bad++; $display("FAIL wl_resp_data: got %h want 84332211", resp_data); end
        req_valid[0] = 1'b0;
        cyc();
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL wl_resp_pulse: got %b want 00", resp_valid); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL wl_after_mem_a: got %h want 0", mem_a); end
    endtask

    task automatic test_signed_loads();
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'h10, 32'h10, 32'h20, 32'h20};
        int          lt  [4] = '{3, 3, 4, 4};
        logic [31:0] ex  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF234, 32'h0000F234};
        int lat;
        for (int t = 0; t < 4; t++) begin
            set_req(0, 1'b0, sz[t], sg[t], ad[t], 32'h0);
            wait_resp(0, 10, lat);
            total++; if (lat !== lt[t]) begin bad++; $display("FAIL ld_latency[%0d]: got %0d want %0d", t, lat, lt[t]); end
            total++; if (resp_data !== ex[t]) begin bad++; $display("FAIL ld_data[%0d]: got %h want %h", t, resp_data, ex[t]); end
            req_valid[0] = 1'b0;
            cyc();
        end
    endtask

    task automatic test_round_robin();
        int          ev_cyc [4];
        logic [1:0]  ev_rv  [4];
        logic [31:0] ev_dat [4];
        int n;
        do_reset();
        for (int k = 0; k < 4; k++) begin ev_cyc[k] = 0; ev_rv[k] = '0; ev_dat[k] = '0; end
        n = 0;
        set_req(0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        set_req(1, 1'b0, 2'd0, 1'b0, 32'h50, 32'h0);
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (resp_valid != 2'b00 && n < 4) begin
                ev_cyc[n] = c; ev_rv[n] = resp_valid; ev_dat[n] = resp_data; n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (ev_cyc[k] !== 3 * (k + 1)) begin bad++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", k, ev_cyc[k], 3 * (k + 1)); end
            total++; if (ev_rv[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_channel[%0d]: got %b want %b", k, ev_rv[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
            total++; if (ev_dat[k] !== ((k % 2 == 0) ? 32'hA0 : 32'h5B)) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, ev_dat[k], (k % 2 == 0) ? 32'hA0 : 32'h5B); end
        end
        req_valid = '0;
        do_reset();
        // A lone continuous requester must wait one cycle after each response.
        n = 0;
        for (int k = 0; k < 4; k++) ev_cyc[k] = 0;
        set_req(0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (resp_valid[0] && n < 3) begin ev_cyc[n] = c; n++; end
        end
        for (int k = 0; k < 3; k++) begin
            total++; if (ev_cyc[k] !== 3 + 4 * k) begin bad++; $display("FAIL rr_excl_cycle[%0d]: got %0d want %0d", k, ev_cyc[k], 3 + 4 * k); end
        end
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_io_store();
        io_buffer_full = 1'b1;
        set_req(1, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h00000041);
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL io_hold_mem_wr[%0d]: got %b want 0", i, mem_wr); end
            total++; if (mem_a !== 32'h30000) begin bad++; $display("FAIL io_hold_mem_a[%0d]: got %h want 30000", i, mem_a); end
        end
        cyc();
        io_buffer_full = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL io_write_mem_wr: got %b want 1", mem_wr); end
        total++; if (mem_dout !== 8'h41) begin bad++; $display("FAIL io_write_dout: got %h want 41", mem_dout); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL io_resp_early: got %b want 00", resp_valid); end
        cyc();
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL io_resp_valid: got %b want 10", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL io_resp_data: got %h want 0", resp_data); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL io_after_mem_wr: got %b want 0", mem_wr); end
        req_valid[1] = 1'b0;
        cyc();
    endtask

    task automatic test_flush();
        logic [31:0] wd = 32'hA1B2C3D4;
        int pulses;
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        cyc();
        cyc();
        flush = 1'b1;
        req_valid[0] = 1'b0;
        cyc();
        flush = 1'b0;
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL flush_rd_idle_mem_a: got %h want 0", mem_a); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (resp_valid != 2'b00) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL flush_rd_resp: got %0d pulses want 0", pulses); end
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h200, wd);
        for (int i = 0; i < 4; i++) begin
            cyc();
            flush = (i == 1);
            #1;
            total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL flush_wr_mem_wr[%0d]: got %b want 1", i, mem_wr); end
            total++; if (mem_a !== 32'h200 + 32'(i)) begin bad++; $display("FAIL flush_wr_mem_a[%0d]: got %h want %h", i, mem_a, 32'h200 + 32'(i)); end
            total++; if (mem_dout !== wd[8*i +: 8]) begin bad++; $display("FAIL flush_wr_dout[%0d]: got %h want %h", i, mem_dout, wd[8*i +: 8]); end
        end
        cyc();
        flush = 1'b0;
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL flush_wr_resp: got %b want 01", resp_valid); end
        req_valid[0] = 1'b0;
        cyc();
    endtask

    task automatic test_freeze_then_reset();
        int lat;
        int pulses;
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        cyc();
        cyc();
        cyc();
        rdy_in = 1'b0;
        #1;
        total++; if (mem_a !== 32'h102) begin bad++; $display("FAIL frz_mem_a: got %h want 102", mem_a); end
        cyc();
        total++; if (mem_a !== 32'h102) begin bad++; $display("FAIL frz_hold_mem_a: got %h want 102", mem_a); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL frz_resp: got %b want 00", resp_valid); end
        cyc();
        rdy_in = 1'b1;
        wait_resp(0, 10, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL frz_latency: got %0d want 3", lat); end
        total++; if (resp_data !== 32'h84332211) begin bad++; $display("FAIL frz_data: got %h want 84332211", resp_data); end
        req_valid[0] = 1'b0;
        cyc();
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h55667788);
        cyc();
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rst_store_started: got %b want 1", mem_wr); end
        cyc();
        rst_in = 1'b0;
        #1;
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rst_mid_mem_a: got %h want 0", mem_a); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_wr: got %b want 0", mem_wr); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL rst_mid_mem_dout: got %h want 0", mem_dout); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_mid_resp_data: got %h want 0", resp_data); end
        req_valid = '0;
        cyc();
        cyc();
        rst_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (resp_valid != 2'b00) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_store_resp: got %0d pulses want 0", pulses); end
        set_req(0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        set_req(1, 1'b0, 2'd0, 1'b0, 32'h50, 32'h0);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (resp_valid != 2'b00) begin lat = i; break; end
        end
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL rst_rr_first: got %b want 01", resp_valid); end
        total++; if (lat !== 3) begin bad++; $display("FAIL rst_rr_latency: got %0d want 3", lat); end
        req_valid = '0;
        cyc();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h84;
        mem[8'h10] = 8'h80;
        mem[8'h20] = 8'h34; mem[8'h21] = 8'hF2;
        mem[8'h40] = 8'hA0;
        mem[8'h50] = 8'h5B;
        test_reset();
        test_word_load();
        test_signed_loads();
        test_round_robin();
        test_io_store();
        test_flush();
        test_freeze_then_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
